reg_bus_arbiter: RTL and testbench

- Shares the single 16-bit register bus (address, write data, write enable, read data) between NUM_REQ masters, e.g. the UART register bridge and an on-chip sequencer.
- Round-robin arbitration; one transaction in flight at a time.
- Per-requester req/ack handshake; read data is returned with the ack.
- Sits between the masters and the register file / peripheral decode.

---
 rtl/reg_bus_pkg.sv | 12 +
 rtl/reg_bus_rr_pick.sv | 33 +++
 rtl/reg_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared widths and FSM encoding for the register-bus arbiter.
package reg_bus_pkg;
    localparam int REG_AW = 16;
    localparam int REG_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_e;
endpackage

// File: rtl/reg_bus_rr_pick.sv
// Combinational cyclic priority pick: first masked requester at or after ptr.
module reg_bus_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // First pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!valid && j >= int'(ptr) && req[j] && mask[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!valid && req[j] && mask[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = PTR_W'(j);
            end
        end
    end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one 16-bit register bus among NUM_REQ masters.
// Define REG_BUS_ARB_LOCK_EN to let a master hold the grant via i_lock.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int RD_LAT  = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [REG_AW*NUM_REQ-1:0] i_addr,
    input  logic [REG_DW*NUM_REQ-1:0] i_wdata,
    input  logic [NUM_REQ-1:0]        i_lock,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic [REG_DW-1:0]         o_rdata,
    output logic                      o_busy,
    output logic [REG_AW-1:0]         o_rwaddr,
    output logic [REG_DW-1:0]         o_wdata,
    output logic                      o_wen,
    input  logic [REG_DW-1:0]         i_rdata
);
    localparam int PTR_W = $clog2(NUM_REQ);

    state_e             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   idx;
    logic [PTR_W-1:0]   nxt_idx;
    logic               lat_we;
    logic [2:0]         cnt;
    logic               locked;

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               sel_we;
    logic [REG_AW-1:0]  sel_addr;
    logic [REG_DW-1:0]  sel_wdata;

`ifdef REG_BUS_ARB_LOCK_EN
    always_comb begin
        mask = '1;
        if (locked) begin
            mask      = '0;
            mask[idx] = 1'b1;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^i_lock;
    assign mask        = '1;
`endif

    reg_bus_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req   (i_req),
        .mask  (mask),
        .ptr   (ptr),
        .grant (grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_we    = i_we[k];
                sel_addr  = i_addr[k*REG_AW +: REG_AW];
                sel_wdata = i_wdata[k*REG_DW +: REG_DW];
            end
        end
    end

    assign nxt_idx = (idx == PTR_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
    assign o_busy  = (state != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            idx      <= '0;
            lat_we   <= 1'b0;
            cnt      <= '0;
            locked   <= 1'b0;
            o_ack    <= '0;
            o_wen    <= 1'b0;
            o_rwaddr <= '0;
            o_wdata  <= '0;
            o_rdata  <= '0;
        end else begin
            o_ack <= '0;
            o_wen <= 1'b0;
            case (state)
                ST_IDLE: begin
`ifdef REG_BUS_ARB_LOCK_EN
                    if (locked && !i_req[idx]) begin
                        locked <= 1'b0;
                        ptr    <= nxt_idx;
                    end
`endif
                    // Bus address/data are driven straight from the latch so they hold between transactions.
                    if (pick_valid) begin
                        idx      <= pick_idx;
                        lat_we   <= sel_we;
                        o_rwaddr <= sel_addr;
                        o_wdata  <= sel_wdata;
                        o_wen    <= sel_we;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (lat_we || RD_LAT == 0) begin
                        if (!lat_we) o_rdata <= i_rdata;
                        o_ack[idx] <= 1'b1;
                        state      <= ST_ACK;
                    end else begin
                        cnt   <= 3'(RD_LAT);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        o_rdata    <= i_rdata;
                        o_ack[idx] <= 1'b1;
                        state      <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
`ifdef REG_BUS_ARB_LOCK_EN
                    if (i_lock[idx]) begin
                        ptr    <= idx;
                        locked <= 1'b1;
                    end else begin
                        ptr    <= nxt_idx;
                        locked <= 1'b0;
                    end
`else
                    ptr <= nxt_idx;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench: DUT a (NUM_REQ=3, RD_LAT=3) carries most scenarios, DUT b (NUM_REQ=2, RD_LAT=0) the zero-latency read.
module tb_reg_bus_arbiter;
    logic        clk;
    logic        rst;

    logic [2:0]  req_a, we_a, lock_a, ack_a;
    logic [47:0] addr_a, wdata_a;
    logic [15:0] rdata_a, rdout_a, rwaddr_a, wdout_a;
    logic        busy_a, wen_a;

    logic [1:0]  req_b, we_b, lock_b, ack_b;
    logic [31:0] addr_b, wdata_b;
    logic [15:0] rdata_b, rdout_b, rwaddr_b, wdout_b;
    logic        busy_b, wen_b;

    int checks;
    int failures;

    reg_bus_arbiter #(.NUM_REQ(3), .RD_LAT(3)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_we(we_a), .i_addr(addr_a),
        .i_wdata(wdata_a), .i_lock(lock_a), .o_ack(ack_a), .o_rdata(rdout_a),
        .o_busy(busy_a), .o_rwaddr(rwaddr_a), .o_wdata(wdout_a), .o_wen(wen_a),
        .i_rdata(rdata_a)
    );

    reg_bus_arbiter #(.NUM_REQ(2), .RD_LAT(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_we(we_b), .i_addr(addr_b),
        .i_wdata(wdata_b), .i_lock(lock_b), .o_ack(ack_b), .o_rdata(rdout_b),
        .o_busy(busy_b), .o_rwaddr(rwaddr_b), .o_wdata(wdout_b), .o_wen(wen_b),
        .i_rdata(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset values, then pointer must start at 0: req0 beats req2.
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ack_a !== 3'b000 || wen_a !== 1'b0 || busy_a !== 1'b0 || rwaddr_a !== 16'h0
            || wdout_a !== 16'h0 || rdout_a !== 16'h0) begin
            failures++;
            $display("FAIL reset_state ack=%b wen=%b busy=%b addr=%h wd=%h rd=%h expected all zero",
                     ack_a, wen_a, busy_a, rwaddr_a, wdout_a, rdout_a);
        end
        rst = 1'b0;
        req_a = 3'b101; we_a = 3'b101;
        addr_a[15:0] = 16'h0A00; addr_a[47:32] = 16'h0A02;
        tick();
        req_a = 3'b000;
        checks++;
        if (rwaddr_a !== 16'h0A00) begin
            failures++;
            $display("FAIL reset_ptr0 addr=%h expected 0a00", rwaddr_a);
        end
        tick();
        checks++;
        if (ack_a !== 3'b001) begin
            failures++;
            $display("FAIL reset_ptr0_ack ack=%b expected 001", ack_a);
        end
        tick();
    endtask

    // Single write; inputs changed and req dropped after the latch.
    task automatic test_write();
        req_a = 3'b001; we_a = 3'b001;
        addr_a[15:0] = 16'h0010; wdata_a[15:0] = 16'hBEEF;
        tick();
        checks++;
        if (wen_a !== 1'b1 || rwaddr_a !== 16'h0010 || wdout_a !== 16'hBEEF || ack_a !== 3'b000 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL write_access wen=%b addr=%h wd=%h ack=%b busy=%b expected 1 0010 beef 000 1",
                     wen_a, rwaddr_a, wdout_a, ack_a, busy_a);
        end
        req_a = 3'b000; we_a = 3'b000;
        addr_a[15:0] = 16'h7777; wdata_a[15:0] = 16'h1111;
        tick();
        checks++;
        if (ack_a !== 3'b001 || wen_a !== 1'b0 || rwaddr_a !== 16'h0010 || wdout_a !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_ack ack=%b wen=%b addr=%h wd=%h expected 001 0 0010 beef",
                     ack_a, wen_a, rwaddr_a, wdout_a);
        end
        tick();
        checks++;
        if (ack_a !== 3'b000 || busy_a !== 1'b0 || wen_a !== 1'b0 || rwaddr_a !== 16'h0010) begin
            failures++;
            $display("FAIL write_idle ack=%b busy=%b wen=%b addr=%h expected 000 0 0 0010",
                     ack_a, busy_a, wen_a, rwaddr_a);
        end
    endtask

    // RD_LAT=3 read: data valid only in cycle 4, ack in cycle 5.
    task automatic test_read_lat();
        req_a = 3'b010; we_a = 3'b000;
        addr_a[31:16] = 16'h0004; rdata_a = 16'hDEAD;
        for (int c = 1; c <= 5; c++) begin
            tick();
            rdata_a = (c == 4) ? 16'h1234 : 16'hDEAD;
            checks++;
            if (wen_a !== 1'b0 || ack_a !== ((c == 5) ? 3'b010 : 3'b000)) begin
                failures++;
                $display("FAIL read_lat_c%0d wen=%b ack=%b expected 0 %b", c, wen_a, ack_a,
                         (c == 5) ? 3'b010 : 3'b000);
            end
        end
        checks++;
        if (rdout_a !== 16'h1234) begin
            failures++;
            $display("FAIL read_lat_data rdata=%h expected 1234", rdout_a);
        end
        req_a = 3'b000;
        tick();
    endtask

    // Pointer wraps 2->0 for req0; reset during WAIT abandons it; req1 then served.
    task automatic test_reset_mid_read();
        req_a = 3'b001; we_a = 3'b000; addr_a[15:0] = 16'h0030;
        tick();
        checks++;
        if (rwaddr_a !== 16'h0030) begin
            failures++;
            $display("FAIL midrd_grant addr=%h expected 0030", rwaddr_a);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = 3'b000;
        checks++;
        if (ack_a !== 3'b000 || rdout_a !== 16'h0 || busy_a !== 1'b0 || rwaddr_a !== 16'h0) begin
            failures++;
            $display("FAIL midrd_reset ack=%b rdata=%h busy=%b addr=%h expected 000 0000 0 0000",
                     ack_a, rdout_a, busy_a, rwaddr_a);
        end
        req_a = 3'b010; we_a = 3'b010;
        addr_a[31:16] = 16'h0002; wdata_a[31:16] = 16'h00AA;
        tick();
        checks++;
        if (wen_a !== 1'b1 || rwaddr_a !== 16'h0002 || wdout_a !== 16'h00AA) begin
            failures++;
            $display("FAIL midrd_write wen=%b addr=%h wd=%h expected 1 0002 00aa", wen_a, rwaddr_a, wdout_a);
        end
        tick();
        checks++;
        if (ack_a !== 3'b010) begin
            failures++;
            $display("FAIL midrd_ack ack=%b expected 010", ack_a);
        end
        req_a = 3'b000;
        tick();
    endtask

    // Continuous req0/req1 writes alternate with acks 3 cycles apart.
    task automatic test_back_to_back();
        logic [2:0] exp;
        req_a = 3'b011; we_a = 3'b011;
        addr_a[15:0] = 16'h0100; addr_a[31:16] = 16'h0101;
        for (int c = 1; c <= 11; c++) begin
            tick();
            case (c)
                2, 8:    exp = 3'b001;
                5, 11:   exp = 3'b010;
                default: exp = 3'b000;
            endcase
            checks++;
            if (ack_a !== exp) begin
                failures++;
                $display("FAIL b2b_c%0d ack=%b expected %b", c, ack_a, exp);
            end
        end
        req_a = 3'b000;
        tick();
    endtask

    // Pointer at 2: req2 then wrap to req0.
    task automatic test_wrap();
        req_a = 3'b101; we_a = 3'b101;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2 || c == 5) begin
                checks++;
                if (ack_a !== ((c == 2) ? 3'b100 : 3'b001)) begin
                    failures++;
                    $display("FAIL wrap_c%0d ack=%b expected %b", c, ack_a, (c == 2) ? 3'b100 : 3'b001);
                end
            end
        end
        req_a = 3'b000;
        tick();
    endtask

    // req0 holds i_lock through two acks; with the lock feature req0 keeps the bus.
    task automatic test_lock();
        logic [2:0] exp;
        req_a = 3'b011; we_a = 3'b011; lock_a = 3'b001;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 9) lock_a = 3'b000;
            if (c % 3 == 2) begin
`ifdef REG_BUS_ARB_LOCK_EN
                exp = (c == 2 || c == 14) ? 3'b010 : 3'b001;
`else
                exp = (c == 5 || c == 11) ? 3'b001 : 3'b010;
`endif
                checks++;
                if (ack_a !== exp) begin
                    failures++;
                    $display("FAIL lock_c%0d ack=%b expected %b", c, ack_a, exp);
                end
            end
        end
        req_a = 3'b000;
        tick();
    endtask

    // RD_LAT=0: i_rdata sampled in the ACCESS cycle itself.
    task automatic test_rdlat0();
        req_b = 2'b10; we_b = 2'b00; addr_b[31:16] = 16'h0020; rdata_b = 16'hFFFF;
        tick();
        rdata_b = 16'h5A5A;
        checks++;
        if (rwaddr_b !== 16'h0020 || wen_b !== 1'b0 || ack_b !== 2'b00) begin
            failures++;
            $display("FAIL rdlat0_access addr=%h wen=%b ack=%b expected 0020 0 00", rwaddr_b, wen_b, ack_b);
        end
        tick();
        rdata_b = 16'h0000;
        checks++;
        if (ack_b !== 2'b10 || rdout_b !== 16'h5A5A) begin
            failures++;
            $display("FAIL rdlat0_ack ack=%b rdata=%h expected 10 5a5a", ack_b, rdout_b);
        end
        req_b = 2'b00;
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        req_a = '0; we_a = '0; lock_a = '0; addr_a = '0; wdata_a = '0; rdata_a = '0;
        req_b = '0; we_b = '0; lock_b = '0; addr_b = '0; wdata_b = '0; rdata_b = '0;
        test_reset();
        test_write();
        test_read_lat();
        test_reset_mid_read();
        test_back_to_back();
        test_wrap();
        test_lock();
        test_rdlat0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
